cordic_result_collector: RTL and testbench

CORDIC_RESULT_COLLECTOR -- requirements
Module: cordic_result_collector

---
 rtl/cordic_result_collector.sv | 114 +++++++++++
 tb/tb_cordic_result_collector.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cordic_result_collector.sv
// CORDIC result collector: applies the quadrant/sign correction to the
// final pipeline stage outputs and buffers corrected results in a small
// circular FIFO with a valid/ready handshake toward the consumer.
module cordic_result_collector #(
  parameter int                        WIDTH = 16,
  parameter int                        DEPTH = 4,
  parameter logic signed [WIDTH-1:0]   PI_Q  = 16'sd25736
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic signed [WIDTH-1:0]     i_x,
  input  logic signed [WIDTH-1:0]     i_y,
  input  logic signed [WIDTH-1:0]     i_z,
  input  logic                        i_mode,
  input  logic                        i_sign,
  output logic signed [WIDTH-1:0]     o_res_a,
  output logic signed [WIDTH-1:0]     o_res_b,
  output logic                        o_mode,
  output logic                        valid_out,
  input  logic                        ready_in,
  output logic [$clog2(DEPTH):0]      o_count,
  output logic                        o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * WIDTH + 1;

  // Negation that maps the most negative value to the most positive one.
  function automatic logic signed [WIDTH-1:0] sat_neg(input logic signed [WIDTH-1:0] v);
    logic signed [WIDTH-1:0] min_v;
    logic signed [WIDTH-1:0] max_v;
    min_v = {1'b1, {(WIDTH-1){1'b0}}};
    max_v = {1'b0, {(WIDTH-1){1'b1}}};
    if (v == min_v) return max_v;
    return -v;
  endfunction

  // Undo the pi pre-reflection on the angle; wraps modulo 2^WIDTH.
  function automatic logic signed [WIDTH-1:0] angle_fix(input logic signed [WIDTH-1:0] z);
    logic signed [WIDTH:0] t;
    if (z <= 0) t = {z[WIDTH-1], z} + {PI_Q[WIDTH-1], PI_Q};
    else        t = {z[WIDTH-1], z} - {PI_Q[WIDTH-1], PI_Q};
    return t[WIDTH-1:0];
  endfunction

  logic signed [WIDTH-1:0] corr_a;
  logic signed [WIDTH-1:0] corr_b;
  logic [EW-1:0]           mem_q [DEPTH];
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [AW:0]             count_q, count_d;
  logic                    ovf_q, ovf_d;
  logic                    full, pop, push;
  logic [EW-1:0]           head;

  // Result correction, purely combinational on the final-stage values.
  always_comb begin
    corr_a = i_x;
    corr_b = i_y;
    if (i_mode) begin
      corr_a = i_x;
      corr_b = i_sign ? angle_fix(i_z) : i_z;
    end else if (i_sign) begin
      corr_a = sat_neg(i_x);
      corr_b = sat_neg(i_y);
    end
  end

  // Handshake decode and next-state for pointers, count and overflow.
  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    pop      = (count_q != '0) && ready_in;
    push     = valid_in && (!full || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    ovf_d    = ovf_q || (valid_in && !push);
  end

  // Control state; asynchronous reset empties the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage write; contents are unobservable while empty so no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {corr_a, corr_b, i_mode};
  end

  // Present the head entry, forced to zero while the buffer is empty.
  always_comb begin
    head       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    o_res_a    = head[EW-1 -: WIDTH];
    o_res_b    = head[WIDTH -: WIDTH];
    o_mode     = head[0];
    valid_out  = (count_q != '0);
    o_count    = count_q;
    o_overflow = ovf_q;
  end

endmodule

// File: tb/tb_cordic_result_collector.sv
// Testbench for cordic_result_collector: directed corner cases followed by
// randomized traffic, compared against a queue-based reference model.
module tb_cordic_result_collector;

  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int PI    = 25736;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     valid_in = 1'b0;
  logic signed [WIDTH-1:0]  i_x = '0;
  logic signed [WIDTH-1:0]  i_y = '0;
  logic signed [WIDTH-1:0]  i_z = '0;
  logic                     i_mode = 1'b0;
  logic                     i_sign = 1'b0;
  logic signed [WIDTH-1:0]  o_res_a;
  logic signed [WIDTH-1:0]  o_res_b;
  logic                     o_mode;
  logic                     valid_out;
  logic                     ready_in = 1'b0;
  logic [2:0]               o_count;
  logic                     o_overflow;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int a;
    int b;
    bit m;
  } res_t;

  res_t q[$];
  bit   ovf_m;

  cordic_result_collector #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PI_Q(16'sd25736)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .i_x       (i_x),
    .i_y       (i_y),
    .i_z       (i_z),
    .i_mode    (i_mode),
    .i_sign    (i_sign),
    .o_res_a   (o_res_a),
    .o_res_b   (o_res_b),
    .o_mode    (o_mode),
    .valid_out (valid_out),
    .ready_in  (ready_in),
    .o_count   (o_count),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Wrap an integer into the signed WIDTH-bit range.
  function automatic int wrap16(input int v);
    int r;
    r = v % 65536;
    if (r < 0) r += 65536;
    if (r >= 32768) r -= 65536;
    return r;
  endfunction

  function automatic res_t model(input bit m, input bit s, input int x, input int y, input int z);
    res_t r;
    r.m = m;
    if (!m) begin
      r.a = s ? ((x == -32768) ? 32767 : -x) : x;
      r.b = s ? ((y == -32768) ? 32767 : -y) : y;
    end else begin
      r.a = x;
      if (!s)        r.b = z;
      else if (z <= 0) r.b = wrap16(z + PI);
      else           r.b = wrap16(z - PI);
    end
    return r;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".count"}, int'(o_count), q.size());
    chk({tag, ".ovf"}, int'(o_overflow), int'(ovf_m));
    chk({tag, ".valid"}, int'(valid_out), int'(q.size() != 0));
    if (q.size() != 0) begin
      chk({tag, ".res_a"}, int'(o_res_a), q[0].a);
      chk({tag, ".res_b"}, int'(o_res_b), q[0].b);
      chk({tag, ".mode"}, int'(o_mode), int'(q[0].m));
    end
  endtask

  // One clock cycle: drive inputs, advance the model, sample after the edge.
  task automatic cyc(input bit v, input bit m, input bit s, input int x, input int y,
                     input int z, input bit rdy, input string tag);
    bit pop, push;
    valid_in = v; i_mode = m; i_sign = s; ready_in = rdy;
    i_x = x[WIDTH-1:0]; i_y = y[WIDTH-1:0]; i_z = z[WIDTH-1:0];
    pop  = (q.size() != 0) && rdy;
    push = v && ((q.size() < DEPTH) || pop);
    if (v && !push) ovf_m = 1'b1;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(model(m, s, x, y, z));
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  function automatic int rnd_val();
    case ($urandom_range(0, 7))
      0: return -32768;
      1: return 32767;
      2: return 0;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    ovf_m = 1'b0;
    // Reset state
    #12;
    chk("rst.count", int'(o_count), 0);
    chk("rst.valid", int'(valid_out), 0);
    chk("rst.ovf", int'(o_overflow), 0);
    chk("rst.res_a", int'(o_res_a), 0);
    chk("rst.res_b", int'(o_res_b), 0);
    chk("rst.mode", int'(o_mode), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Basic rotation and first accept after reset
    cyc(1, 0, 0, 100, -50, 0, 1, "rot0");
    chk("rot0.a_const", int'(o_res_a), 100);
    chk("rot0.b_const", int'(o_res_b), -50);
    cyc(1, 0, 1, -32768, 200, 0, 1, "rot1");
    chk("rot1.a_const", int'(o_res_a), 32767);
    chk("rot1.b_const", int'(o_res_b), -200);
    cyc(1, 1, 1, 77, 5, 1000, 1, "vecp");
    chk("vecp.a_const", int'(o_res_a), 77);
    chk("vecp.b_const", int'(o_res_b), -24736);
    cyc(1, 1, 1, -9, 5, -1000, 1, "vecn");
    chk("vecn.a_const", int'(o_res_a), -9);
    chk("vecn.b_const", int'(o_res_b), 24736);
    cyc(0, 0, 0, 0, 0, 0, 1, "drain0");

    // Fill, then simultaneous push and pop while full
    for (int i = 0; i < DEPTH; i++) cyc(1, 0, 0, i + 1, -(i + 1), 0, 0, "fill");
    cyc(1, 1, 0, 11, 0, 22, 1, "fullpp");
    chk("fullpp.count_const", int'(o_count), 4);
    chk("fullpp.ovf_const", int'(o_overflow), 0);
    cyc(0, 0, 0, 0, 0, 0, 0, "hold");
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 0, 0, 1, "drain1");
    cyc(0, 0, 0, 0, 0, 0, 1, "emptyrdy");

    // Overflow: five pushes with no pops
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 10 * (i + 1), i, 0, 0, "ovf");
    chk("ovf.count_const", int'(o_count), 4);
    chk("ovf.flag_const", int'(o_overflow), 1);
    chk("ovf.first_const", int'(o_res_a), 10);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 0, 0, 0, 1, "ovfdrain");

    // Asynchronous reset with entries buffered
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, i, i, 0, 0, "pre_rst");
    #2 rst = 1'b1;
    #1;
    chk("arst.valid", int'(valid_out), 0);
    chk("arst.count", int'(o_count), 0);
    chk("arst.ovf", int'(o_overflow), 0);
    q.delete();
    ovf_m = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(1, 0, 0, 321, 123, 0, 0, "post_rst");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
          bit'($urandom_range(0, 1)), rnd_val(), rnd_val(), rnd_val(),
          bit'($urandom_range(0, 2) != 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
